// File: rtl/event_stretch.sv
// Multi-channel event stretcher: turns single-cycle event pulses into fixed-length
// LED blinks separated by a fixed dark gap, queueing extra events per channel.
module event_stretch #(
  parameter int          CH   = 8,
  parameter logic [31:0] HOLD = 32'd5_000_000,
  parameter logic [31:0] GAP  = 32'd2_500_000,
  parameter int          PW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] ev,
  input  logic          clr,
  output logic [CH-1:0] led,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] ovf
);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_GAP} state_t;

  localparam logic [PW-1:0] PEND_MAX  = {PW{1'b1}};
  localparam logic [31:0]   HOLD_LAST = HOLD - 32'd1;
  localparam logic [31:0]   GAP_LAST  = GAP - 32'd1;

  state_t        state_q [CH];
  state_t        state_d [CH];
  logic [31:0]   cnt_q   [CH];
  logic [31:0]   cnt_d   [CH];
  logic [PW-1:0] pend_q  [CH];
  logic [PW-1:0] pend_d  [CH];
  logic [CH-1:0] ovf_q, ovf_d;
  logic [CH-1:0] led_q, led_d;
  logic [CH-1:0] queue_ev;

  // Saturating increment: MSB flags a dropped event, low bits are the new count.
  function automatic logic [PW:0] pend_sat_inc(input logic [PW-1:0] p);
    if (p == PEND_MAX) return {1'b1, p};
    else               return {1'b0, p + 1'b1};
  endfunction

  always_comb begin
    ovf_d    = ovf_q;
    led_d    = '0;
    queue_ev = '0;
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pend_d[i]  = pend_q[i];

      case (state_q[i])
        ST_IDLE: begin
          if (ev[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end
        end
        ST_ON: begin
          queue_ev[i] = ev[i];
          if (cnt_q[i] == HOLD_LAST) begin
            state_d[i] = ST_GAP;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 32'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q[i] == GAP_LAST) begin
            cnt_d[i] = '0;
            // A queued blink takes priority; a coincident event simply replaces the one consumed.
            if (pend_q[i] != '0) begin
              state_d[i] = ST_ON;
              if (!ev[i]) pend_d[i] = pend_q[i] - 1'b1;
            end else if (ev[i]) begin
              state_d[i] = ST_ON;
            end else begin
              state_d[i] = ST_IDLE;
            end
          end else begin
            queue_ev[i] = ev[i];
            cnt_d[i]    = cnt_q[i] + 32'd1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase

      if (queue_ev[i]) begin
        {ovf_d[i], pend_d[i]} = pend_sat_inc(pend_q[i]) | {ovf_q[i], {PW{1'b0}}};
      end

      // Clear only touches the queue and overflow flag; a running blink is left alone.
      if (clr) begin
        pend_d[i] = '0;
        ovf_d[i]  = 1'b0;
      end

      led_d[i] = (state_d[i] == ST_ON);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        pend_q[i]  <= '0;
      end
      ovf_q <= '0;
      led_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pend_q[i]  <= pend_d[i];
      end
      ovf_q <= ovf_d;
      led_q <= led_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < CH; i++) begin
      busy[i] = (state_q[i] != ST_IDLE);
    end
  end

  assign led = led_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_event_stretch.sv
// Bench for event_stretch: directed scenarios plus random traffic, every cycle
// compared against a timeline model of blink start times and pending counts.
module tb_event_stretch;

  localparam int CH   = 2;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int PW   = 2;
  localparam int QMAX = (1 << PW) - 1;

  logic          clk;
  logic          rst;
  logic [CH-1:0] ev;
  logic          clr;
  logic [CH-1:0] led;
  logic [CH-1:0] busy;
  logic [CH-1:0] ovf;

  int total = 0;
  int bad   = 0;

  // Reference model: each active channel remembers the edge its current blink began.
  int cyc;
  bit m_act   [CH];
  int m_start [CH];
  int m_pend  [CH];
  bit m_ovf   [CH];

  int led0_cnt;
  int busy0_cnt;

  event_stretch #(
    .CH  (CH),
    .HOLD(32'(HOLD)),
    .GAP (32'(GAP)),
    .PW  (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ev  (ev),
    .clr (clr),
    .led (led),
    .busy(busy),
    .ovf (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_act[i]   = 1'b0;
      m_start[i] = 0;
      m_pend[i]  = 0;
      m_ovf[i]   = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [CH-1:0] e, input logic c);
    for (int i = 0; i < CH; i++) begin
      int p;
      p = cyc - m_start[i];
      if (m_act[i]) begin
        if (p == HOLD + GAP) begin
          if (m_pend[i] > 0) begin
            m_start[i] = cyc;
            m_pend[i]  = m_pend[i] - 1 + int'(e[i]);
          end else if (e[i]) begin
            m_start[i] = cyc;
          end else begin
            m_act[i] = 1'b0;
          end
        end else if (e[i]) begin
          if (m_pend[i] == QMAX) m_ovf[i] = 1'b1;
          else                   m_pend[i] = m_pend[i] + 1;
        end
      end else if (e[i]) begin
        m_act[i]   = 1'b1;
        m_start[i] = cyc;
      end
      if (c) begin
        m_pend[i] = 0;
        m_ovf[i]  = 1'b0;
      end
    end
  endtask

  task automatic expect_vec(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, got, want);
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, got, want);
    end
  endtask

  task automatic check_model();
    logic [CH-1:0] e_led, e_busy, e_ovf;
    for (int i = 0; i < CH; i++) begin
      e_led[i]  = m_act[i] && ((cyc - m_start[i]) < HOLD);
      e_busy[i] = m_act[i];
      e_ovf[i]  = m_ovf[i];
    end
    expect_vec("led", led, e_led);
    expect_vec("busy", busy, e_busy);
    expect_vec("ovf", ovf, e_ovf);
  endtask

  // Drive inputs, take one rising edge, advance the model, check 1 time unit later.
  task automatic step(input logic [CH-1:0] e, input logic c);
    ev  = e;
    clr = c;
    @(posedge clk);
    cyc++;
    if (rst) model_edge(e, c);
    else     model_reset();
    #1;
    check_model();
    led0_cnt  += int'(led[0]);
    busy0_cnt += int'(busy[0]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0);
  endtask

  task automatic zero_counts();
    led0_cnt  = 0;
    busy0_cnt = 0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    zero_counts();
    rst = 1'b0;
    ev  = 2'b11;
    clr = 1'b0;

    // Reset state with events driven.
    #1;
    check_model();
    step(2'b11, 1'b0);
    step(2'b11, 1'b0);
    expect_vec("rst_led", led, 2'b00);
    expect_vec("rst_ovf", ovf, 2'b00);
    rst = 1'b1;

    // Single pulse on channel 0.
    zero_counts();
    step(2'b01, 1'b0);
    idle(10);
    expect_int("single_led_len", led0_cnt, HOLD);
    expect_int("single_busy_len", busy0_cnt, HOLD + GAP);
    expect_vec("single_ch1_idle", led & 2'b10, 2'b00);

    // Burst of three pulses.
    zero_counts();
    for (int k = 0; k < 3; k++) step(2'b01, 1'b0);
    idle(24);
    expect_int("burst_led_len", led0_cnt, 3 * HOLD);
    expect_int("burst_busy_len", busy0_cnt, 3 * (HOLD + GAP));
    expect_vec("burst_ovf", ovf, 2'b00);

    // Saturation: five pulses, one active plus three queued.
    zero_counts();
    for (int k = 0; k < 5; k++) step(2'b01, 1'b0);
    idle(8);
    expect_int("sat_ovf_set", int'(ovf[0]), 1);
    step(2'b00, 1'b1);
    expect_int("sat_ovf_clr", int'(ovf[0]), 0);
    expect_int("sat_blink_kept", int'(led[0]), 1);
    idle(30);
    expect_int("sat_led_len", led0_cnt, 3 * HOLD);
    expect_int("sat_idle_after", int'(busy[0]), 0);

    // Event on the last gap cycle restarts with no idle cycle.
    zero_counts();
    step(2'b01, 1'b0);
    idle(HOLD + GAP - 1);
    step(2'b01, 1'b0);
    expect_int("gapedge_led", int'(led[0]), 1);
    idle(10);
    expect_int("gapedge_busy_len", busy0_cnt, 2 * (HOLD + GAP));
    expect_int("gapedge_led_len", led0_cnt, 2 * HOLD);

    // clr and ev in the same cycle during ON.
    zero_counts();
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    step(2'b01, 1'b1);
    idle(15);
    expect_int("collide_led_len", led0_cnt, HOLD);
    expect_int("collide_busy_len", busy0_cnt, HOLD + GAP);

    // Asynchronous reset mid-blink with a queue behind it.
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    expect_int("arst_led_now", int'(led[0]), 0);
    expect_int("arst_busy_now", int'(busy[0]), 0);
    step(2'b00, 1'b0);
    step(2'b00, 1'b0);
    rst = 1'b1;
    zero_counts();
    idle(20);
    expect_int("arst_no_replay", led0_cnt, 0);

    // Random traffic on both channels.
    for (int k = 0; k < 600; k++) begin
      logic [CH-1:0] e;
      for (int i = 0; i < CH; i++) e[i] = ($urandom_range(0, 4) == 0);
      step(e, $urandom_range(0, 40) == 0);
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
